// File: rtl/ascon_stream_driver.sv
// Byte-serial host stream <-> ASCON-128a 128-bit block interface: packs key/nonce/AD/payload and unpacks result/tag bytes.
// Latency: last byte at t gives core_start at t+1 if the core is ready; input stalls outside FILL, and output bytes hold while m_ready is low.
module ascon_stream_driver (
    input  logic         clk,
    input  logic         rstn,
    input  logic [7:0]   s_data,
    input  logic [1:0]   s_kind,
    input  logic         s_last,
    input  logic         s_empty,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         decrypt,
    output logic [7:0]   m_data,
    output logic         m_tag,
    output logic         m_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         err,
    output logic         core_decrypt,
    output logic [7:0]   core_len,
    output logic [127:0] core_blk,
    output logic         core_start,
    input  logic         core_rdy,
    input  logic [2:0]   core_type,
    input  logic [127:0] core_out
);

    typedef enum logic [2:0] {FILL, ISSUE, SETTLE, WAIT, DRAIN, ERR} state_t;
    // Phase encoding matches the core's blk_type, so phase and core_type compare directly.
    typedef enum logic [2:0] {
        NEED_KEY   = 3'd0,
        NEED_NONCE = 3'd1,
        AD         = 3'd2,
        PT         = 3'd3,
        FIN        = 3'd4
    } phase_t;

    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic [127:0]   blk_q, blk_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           last_q, last_d;
    logic           term_q, term_d;
    logic [127:0]   obuf_q, obuf_d;
    logic [4:0]     drem_q, drem_d;
    logic           tag_q, tag_d;
    logic           dec_q, dec_d;
    logic           rdy_q;
    logic           pt_post;
    logic [6:0]     bidx;
    logic [4:0]     cnt_inc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FILL;
            phase_q <= NEED_KEY;
            blk_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            term_q  <= 1'b0;
            obuf_q  <= '0;
            drem_q  <= '0;
            tag_q   <= 1'b0;
            dec_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            term_q  <= term_d;
            obuf_q  <= obuf_d;
            drem_q  <= drem_d;
            tag_q   <= tag_d;
            dec_q   <= dec_d;
            rdy_q   <= (state_d == FILL);
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        blk_d      = blk_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        term_d     = term_q;
        obuf_d     = obuf_q;
        drem_d     = drem_q;
        tag_d      = tag_q;
        dec_d      = dec_q;
        pt_post    = 1'b0;
        core_start = 1'b0;
        bidx       = 7'd127 - {cnt_q[3:0], 3'b000};
        cnt_inc    = cnt_q + 5'd1;

        case (state_q)
            FILL: begin
                if (s_valid) begin
                    if (phase_q == FIN || s_kind != phase_q[1:0]) begin
                        state_d = ERR;
                    end else if (s_empty) begin
                        if (!s_last || phase_q == NEED_KEY || phase_q == NEED_NONCE) begin
                            state_d = ERR;
                        end else begin
                            last_d  = 1'b1;
                            term_d  = 1'b0;
                            state_d = ISSUE;
                        end
                    end else begin
                        blk_d[bidx -: 8] = s_data;
                        cnt_d            = cnt_inc;
                        if (phase_q == NEED_NONCE && cnt_q == 5'd0)
                            dec_d = decrypt;
                        if (phase_q == NEED_KEY || phase_q == NEED_NONCE) begin
                            // Key and nonce are exactly one full block.
                            if (s_last != (cnt_inc == 5'd16))
                                state_d = ERR;
                            else if (s_last)
                                state_d = ISSUE;
                        end else if (s_last || cnt_inc == 5'd16) begin
                            last_d  = s_last;
                            term_d  = s_last && (cnt_inc == 5'd16);
                            state_d = ISSUE;
                        end
                    end
                end
            end
            ISSUE: begin
                if (core_rdy) begin
                    if (core_type == phase_q) begin
                        core_start = 1'b1;
                        state_d    = SETTLE;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (core_rdy) begin
                    blk_d = '0;
                    cnt_d = '0;
                    case (phase_q)
                        NEED_KEY: begin
                            phase_d = NEED_NONCE;
                            state_d = FILL;
                        end
                        NEED_NONCE: begin
                            phase_d = AD;
                            state_d = FILL;
                        end
                        AD: begin
                            if (term_q) begin
                                term_d  = 1'b0;
                                state_d = ISSUE;
                            end else if (last_q) begin
                                last_d  = 1'b0;
                                phase_d = PT;
                                state_d = FILL;
                            end else begin
                                state_d = FILL;
                            end
                        end
                        PT: begin
                            if (cnt_q != 5'd0) begin
                                obuf_d  = core_out;
                                drem_d  = cnt_q;
                                state_d = DRAIN;
                            end else begin
                                pt_post = 1'b1;
                            end
                        end
                        default: begin
                            obuf_d  = core_out;
                            drem_d  = 5'd16;
                            tag_d   = 1'b1;
                            phase_d = NEED_NONCE;
                            state_d = DRAIN;
                        end
                    endcase
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    obuf_d = obuf_q << 8;
                    drem_d = drem_q - 5'd1;
                    if (drem_q == 5'd1) begin
                        tag_d = 1'b0;
                        if (phase_q == PT)
                            pt_post = 1'b1;
                        else
                            state_d = FILL;
                    end
                end
            end
            default: state_d = ERR;
        endcase

        // After a payload block: send the pending empty block, or close the message with the final block.
        if (pt_post) begin
            if (term_q) begin
                term_d  = 1'b0;
                state_d = ISSUE;
            end else if (last_q) begin
                last_d  = 1'b0;
                phase_d = FIN;
                state_d = ISSUE;
            end else begin
                state_d = FILL;
            end
        end
    end

    assign s_ready      = rdy_q;
    assign m_valid      = (state_q == DRAIN);
    assign m_data       = obuf_q[127:120];
    assign m_tag        = tag_q;
    assign m_last       = (state_q == DRAIN) && (drem_q == 5'd1);
    assign err          = (state_q == ERR);
    assign core_decrypt = dec_q;
    assign core_len     = {cnt_q, 3'b000};
    assign core_blk     = blk_q;

endmodule

// File: tb/tb_ascon_stream_driver.sv
// Directed bench for ascon_stream_driver with a small behavioural model of the core's block handshake.
module tb_ascon_stream_driver;

    localparam logic [127:0] KEY    = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] NONCE  = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] AD_BLK = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    localparam logic [127:0] PT_BLK = 128'h11121314150000000000000000000000;
    localparam logic [127:0] PT_OUT = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
    localparam logic [127:0] TAG    = 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF;

    logic         clk = 1'b0;
    logic         rstn;
    logic [7:0]   s_data;
    logic [1:0]   s_kind;
    logic         s_last, s_empty, s_valid, s_ready, decrypt;
    logic [7:0]   m_data;
    logic         m_tag, m_last, m_valid, m_ready, err;
    logic         core_decrypt, core_start, core_rdy;
    logic [7:0]   core_len;
    logic [127:0] core_blk, core_out;
    logic [2:0]   core_type;

    int checks = 0;
    int errors = 0;

    logic [2:0]   q_t[$];
    logic [7:0]   q_l[$];
    logic [127:0] q_b[$];

    always #5 clk = ~clk;

    ascon_stream_driver dut (
        .clk(clk), .rstn(rstn),
        .s_data(s_data), .s_kind(s_kind), .s_last(s_last), .s_empty(s_empty),
        .s_valid(s_valid), .s_ready(s_ready), .decrypt(decrypt),
        .m_data(m_data), .m_tag(m_tag), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .err(err), .core_decrypt(core_decrypt), .core_len(core_len), .core_blk(core_blk),
        .core_start(core_start), .core_rdy(core_rdy), .core_type(core_type), .core_out(core_out)
    );

    task automatic chk(input string tg, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
        end
    endtask

    // Core: logs each start, drops ready after non-key blocks, then presents the next expected type.
    int           busy;
    bit           pend;
    logic [2:0]   last_t, nxt_t;
    logic [127:0] nxt_o;
    initial begin
        core_rdy = 1'b1; core_type = 3'd0; core_out = '0;
        busy = 0; pend = 0; last_t = 3'd0; nxt_t = 3'd0; nxt_o = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                core_rdy = 1'b1; core_type = 3'd0; busy = 0; pend = 0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    core_rdy = 1'b1; core_type = nxt_t; core_out = nxt_o;
                end
            end else if (pend) begin
                pend = 0;
                if (last_t == 3'd0) core_type = 3'd1;
                else begin core_rdy = 1'b0; busy = 3; end
            end else if (core_start) begin
                q_t.push_back(core_type); q_l.push_back(core_len); q_b.push_back(core_blk);
                last_t = core_type; pend = 1;
                case (core_type)
                    3'd1: nxt_t = 3'd2;
                    3'd2: nxt_t = (core_len == 8'd128) ? 3'd2 : 3'd3;
                    3'd3: begin nxt_t = (core_len == 8'd128) ? 3'd3 : 3'd4; nxt_o = PT_OUT; end
                    3'd4: begin nxt_t = 3'd1; nxt_o = TAG; end
                    default: nxt_t = 3'd1;
                endcase
            end
        end
    end

    task automatic beat(input logic [1:0] k, input logic [7:0] d, input logic l, input logic e);
        int n = 0;
        s_valid = 1'b1; s_kind = k; s_data = d; s_last = l; s_empty = e;
        while (!s_ready && n < 100) begin @(negedge clk); n++; end
        chk("beat_rdy", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0;
    endtask

    task automatic send(input logic [1:0] k, input logic [7:0] first, input int cnt);
        logic [7:0] b;
        for (int i = 0; i < cnt; i++) begin
            b = first + 8'(i);
            beat(k, b, i == cnt - 1, 1'b0);
        end
    endtask

    task automatic expect_blk(input string tg, input logic [2:0] t, input logic [7:0] len, input logic [127:0] blk);
        int n = 0;
        while (q_t.size() == 0 && n < 200) begin @(negedge clk); n++; end
        chk({tg, "_seen"}, q_t.size() > 0, 1);
        if (q_t.size() > 0) begin
            chk({tg, "_type"}, q_t.pop_front(), t);
            chk({tg, "_len"},  q_l.pop_front(), len);
            chk({tg, "_blk"},  q_b.pop_front(), blk);
        end
    endtask

    task automatic recv(input string tg, input logic [7:0] d, input logic tg_b, input logic l);
        int n = 0;
        while (!m_valid && n < 100) begin @(negedge clk); n++; end
        chk({tg, "_vld"}, m_valid, 1);
        chk({tg, "_byte"}, {m_data, m_tag, m_last}, {d, tg_b, l});
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_kind = '0; s_last = 1'b0; s_empty = 1'b0;
        decrypt = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_out", {m_data, m_tag, m_last}, 0);
        chk("rst_err", err, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_len", core_len, 0);
        chk("rst_core_blk", core_blk, 0);
        chk("rst_core_dec", core_decrypt, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", s_ready, 1);

        // Empty AD and payload: final block follows automatically, then tag.
        send(2'd0, 8'h00, 16);
        expect_blk("key", 3'd0, 8'd128, KEY);
        send(2'd1, 8'h10, 16);
        expect_blk("nonce", 3'd1, 8'd128, NONCE);
        chk("dec_enc", core_decrypt, 0);
        beat(2'd2, 8'h00, 1'b1, 1'b1);
        expect_blk("ad_empty", 3'd2, 8'd0, '0);
        beat(2'd3, 8'h00, 1'b1, 1'b1);
        expect_blk("pt_empty", 3'd3, 8'd0, '0);
        expect_blk("fin1", 3'd4, 8'd0, '0);
        for (int i = 0; i < 16; i++) recv("tag1", 8'hE0 + 8'(i), 1'b1, i == 15);

        // Full AD block with terminating empty block, short payload, output stall.
        decrypt = 1'b1;
        send(2'd1, 8'h10, 16);
        decrypt = 1'b0;
        expect_blk("nonce2", 3'd1, 8'd128, NONCE);
        chk("dec_dec", core_decrypt, 1);
        send(2'd2, 8'hA0, 16);
        expect_blk("ad_full", 3'd2, 8'd128, AD_BLK);
        expect_blk("ad_term", 3'd2, 8'd0, '0);
        send(2'd3, 8'h11, 5);
        expect_blk("pt_short", 3'd3, 8'd40, PT_BLK);
        n = 0;
        while (!m_valid && n < 100) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            chk("stall_vld", m_valid, 1);
            chk("stall_byte", {m_data, m_tag, m_last}, {8'hC0, 1'b0, 1'b0});
            chk("stall_s_ready", s_ready, 0);
            chk("stall_start", core_start, 0);
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) recv("pt_out", 8'hC0 + 8'(i), 1'b0, i == 4);
        expect_blk("fin2", 3'd4, 8'd0, '0);
        for (int i = 0; i < 16; i++) recv("tag2", 8'hE0 + 8'(i), 1'b1, i == 15);

        // Wrong kind in nonce phase is a sticky error.
        chk("err_before", err, 0);
        beat(2'd3, 8'h55, 1'b0, 1'b0);
        chk("err_set", err, 1);
        chk("err_s_ready", s_ready, 0);
        repeat (5) @(negedge clk);
        chk("err_sticky", err, 1);
        chk("err_s_ready_hold", s_ready, 0);
        chk("err_m_valid", m_valid, 0);
        rstn = 1'b0;
        #1;
        chk("err_cleared", err, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_err", s_ready, 1);

        // Reset while waiting on the nonce block.
        send(2'd0, 8'h00, 16);
        expect_blk("key2", 3'd0, 8'd128, KEY);
        decrypt = 1'b1;
        send(2'd1, 8'h10, 16);
        decrypt = 1'b0;
        expect_blk("nonce3", 3'd1, 8'd128, NONCE);
        repeat (2) @(negedge clk);
        chk("wait_dec", core_decrypt, 1);
        chk("wait_len", core_len, 128);
        rstn = 1'b0;
        #1;
        chk("mid_rst_dec", core_decrypt, 0);
        chk("mid_rst_len", core_len, 0);
        chk("mid_rst_blk", core_blk, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_start", core_start, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_err", err, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send(2'd0, 8'h00, 16);
        expect_blk("key3", 3'd0, 8'd128, KEY);
        send(2'd1, 8'h10, 16);
        expect_blk("nonce4", 3'd1, 8'd128, NONCE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
